// File: rtl/param_datapath.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : param_datapath
// Brief    : Parametrised single-cycle datapath (PC, 2R1W register file, ALU,
//            next-PC) with an iterative shift-add multiplier and memory stall.
// Revision : 1.0 - initial release
// ============================================================================
module param_datapath #(
  parameter int DWIDTH  = 8,
  parameter int IWIDTH  = 16,
  parameter int REGBITS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memtoreg,
  input  logic              branch,
  input  logic              alusrc,
  input  logic              regdst,
  input  logic              regwrite,
  input  logic              jump,
  input  logic [3:0]        alucontrol,
  input  logic              memready,
  input  logic [IWIDTH-1:0] instr,
  input  logic [DWIDTH-1:0] readdata,
  output logic              pcsrc,
  output logic              zero,
  output logic [DWIDTH-1:0] pc,
  output logic [DWIDTH-1:0] aluout,
  output logic [DWIDTH-1:0] writedata,
  output logic              stall,
  output logic              busy
);

  localparam int NREGS = 2**REGBITS;
  localparam int IMMW  = IWIDTH - 4 - 2*REGBITS;
  localparam int JTW   = IWIDTH - 4;
  localparam int SHW   = $clog2(DWIDTH);
  localparam int CW    = $clog2(DWIDTH);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1001;
  localparam logic [3:0] ALU_MUL = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

  mul_state_t        state;
  logic [REGBITS-1:0] rs, rt, rd, waddr;
  logic [DWIDTH-1:0]  imm_ext, jtarget;
  logic [DWIDTH-1:0]  regs [NREGS];
  logic [DWIDTH-1:0]  rs_val, rt_val, alu_b, alu_res, wdata, pc_next;
  logic [DWIDTH-1:0]  product, mcand, mplier;
  logic [CW-1:0]      count;
  logic [SHW-1:0]     shamt;
  logic               mem_stall, mul_stall;
  logic               unused_op;

  assign rs = instr[IWIDTH-5 -: REGBITS];
  assign rt = instr[IWIDTH-5-REGBITS -: REGBITS];
  assign rd = instr[IWIDTH-5-2*REGBITS -: REGBITS];
  assign unused_op = ^instr[IWIDTH-1:IWIDTH-4];

  generate
    if (IMMW >= DWIDTH) begin : g_imm_trunc
      assign imm_ext = instr[DWIDTH-1:0];
    end else begin : g_imm_sext
      assign imm_ext = {{(DWIDTH-IMMW){instr[IMMW-1]}}, instr[IMMW-1:0]};
    end
    if (JTW >= DWIDTH) begin : g_jt_trunc
      assign jtarget = instr[DWIDTH-1:0];
    end else begin : g_jt_zext
      assign jtarget = {{(DWIDTH-JTW){1'b0}}, instr[JTW-1:0]};
    end
  endgenerate

  // r0 is hard-wired to zero on both read ports
  assign rs_val    = (rs == '0) ? '0 : regs[rs];
  assign rt_val    = (rt == '0) ? '0 : regs[rt];
  assign writedata = rt_val;
  assign alu_b     = alusrc ? imm_ext : rt_val;
  assign shamt     = alu_b[SHW-1:0];
  assign waddr     = regdst ? rd : rt;
  assign wdata     = memtoreg ? readdata : aluout;

  always_comb begin
    alu_res = '0;
    case (alucontrol)
      ALU_ADD: alu_res = rs_val + alu_b;
      ALU_SUB: alu_res = rs_val - alu_b;
      ALU_AND: alu_res = rs_val & alu_b;
      ALU_OR:  alu_res = rs_val | alu_b;
      ALU_XOR: alu_res = rs_val ^ alu_b;
      ALU_NOR: alu_res = ~(rs_val | alu_b);
      ALU_SLT: alu_res = {{(DWIDTH-1){1'b0}}, ($signed(rs_val) < $signed(alu_b))};
      ALU_SLL: alu_res = rs_val << shamt;
      ALU_SRL: alu_res = rs_val >> shamt;
      ALU_SRA: alu_res = $signed(rs_val) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  assign aluout = (busy || alucontrol == ALU_MUL) ? product : alu_res;
  assign zero   = (aluout == '0);
  assign pcsrc  = branch & zero;

  assign mem_stall = memtoreg & ~memready;
  assign mul_stall = ((state == S_IDLE) && (alucontrol == ALU_MUL)) || (state == S_RUN);
  assign stall     = mem_stall | mul_stall;

  always_comb begin
    pc_next = pc + DWIDTH'(1);
    if (jump)
      pc_next = jtarget;
    else if (pcsrc)
      pc_next = pc + DWIDTH'(1) + imm_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc <= '0;
    else if (!stall)
      pc <= pc_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (regwrite && !stall && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // DONE is held while a concurrent memory stall blocks the writeback
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (alucontrol == ALU_MUL) begin
            mcand   <= rs_val;
            mplier  <= alu_b;
            product <= '0;
            count   <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (alucontrol != ALU_MUL) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            if (mplier[0])
              product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (count == CW'(DWIDTH-1)) begin
              busy  <= 1'b0;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if ((alucontrol != ALU_MUL) || !mem_stall)
            state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
